mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Multicycle MIPS control unit that sequences the shared datapath: PC, instruction register, register file, the single ALU and unified memory. It decodes `opcode` and `funct` from the IR and steps each instruction through fetch, decode, execute, memory and writeback states, one state per clock. It drives every datapath mux select and write enable, and waits on a memory-ready handshake for each memory access. It sits beside the datapath inside the CPU top and replaces single-cycle combinational decode.

## Interface
- No parameters. Opcode, funct and ALU encodings are fixed below.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, current cycle.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `pc_en` out 1: PC register load.
- `pc_source` out 2: next-PC select. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: IR load.
- `reg_dst` out 1: write-register select. 0 = rt, 1 = rd.
- `mem_to_reg` out 1: write-data select. 0 = ALUOut, 1 = MDR.
- `reg_write` out 1: register file write.
- `alu_src_a` out 1: ALU A select. 0 = PC, 1 = A register.
- `alu_src_b` out 2: ALU B select. 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `ext_zero` out 1: zero-extend the immediate instead of sign-extending (andi/ori).
- `alu_ctrl` out 3: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `state` out 4: current state, for debug.
- `instr_done` out 1: one-cycle pulse on the last cycle of each instruction.
- `illegal` out 1: one-cycle pulse when the opcode or funct is undecodable.

## Operation
- State encoding:
  - IF=0, ID=1, MADDR=2, MRD=3, MWB=4, MWR=5, REX=6, RWB=7, IEX=8, IWB=9, BR=10, JMP=11.
  - Codes 12–15 are unreachable. If entered, the next state is IF.
- Outputs are Moore, decoded from `state`, except where gated by `mem_ready` or `zero`. Every output not listed for a state is 0.
- IF:
  - Asserts `mem_read`, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, ADD, `pc_source`=00.
  - `ir_write` and `pc_en` equal `mem_ready`.
  - Stays in IF until `mem_ready`=1, then goes to ID.
- ID:
  - `alu_src_a`=0, `alu_src_b`=11, ADD. This computes the branch target into ALUOut.
  - Dispatch on opcode:
    - 100011 (lw) or 101011 (sw) → MADDR.
    - 000000 → REX.
    - 001000 (addi), 001100 (andi), 001101 (ori) → IEX.
    - 000100 (beq), 000101 (bne) → BR.
    - 000010 (j) → JMP.
    - Any other opcode → IF, with `illegal`=1 and `instr_done`=1.
- MADDR: `alu_src_a`=1, `alu_src_b`=10, ADD. Goes to MRD for lw, MWR for sw.
- MRD: `mem_read`=1, `iord`=1. Waits for `mem_ready`, then goes to MWB.
- MWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1, `instr_done`=1. Goes to IF.
- MWR:
  - `mem_write`=1, `iord`=1, held until `mem_ready`.
  - `instr_done`=`mem_ready`.
  - Goes to IF when `mem_ready`=1.
- REX:
  - `alu_src_a`=1, `alu_src_b`=00.
  - `alu_ctrl` from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
  - Unknown funct: `illegal`=1 and `instr_done`=1, next state IF, RWB skipped.
- RWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1. Goes to IF.
- IEX:
  - `alu_src_a`=1, `alu_src_b`=10.
  - `alu_ctrl`: ADD for addi, AND for andi, OR for ori.
  - `ext_zero`=1 for andi and ori.
- IWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, `instr_done`=1. Goes to IF.
- BR:
  - `alu_src_a`=1, `alu_src_b`=00, SUB, `pc_source`=01, `instr_done`=1. Goes to IF.
  - `pc_en`=`zero` for beq, `pc_en`=~`zero` for bne.
- JMP: `pc_source`=10, `pc_en`=1, `instr_done`=1. Goes to IF.
- `opcode` and `funct` must be stable from ID through the end of the instruction. The IR is only written in IF.

## Timing
- With `mem_ready` tied to 1, cycles per instruction:
  - lw 5, sw 4, R-type 4, I-ALU 4, beq/bne 3, j 3.
  - Illegal opcode 2. Illegal funct 3.
- Each cycle of `mem_ready`=0 in IF, MRD or MWR adds exactly one cycle.
- Reset:
  - A clock edge with `rst`=1 forces `state`=IF.
  - While `rst`=1, all outputs are forced to 0 combinationally: `pc_en`, `ir_write`, `reg_write`, `mem_write`, `mem_read`, `instr_done`, `illegal`, and all selects.
  - Reset mid-instruction abandons it with no further writes.
  - In the first cycle after reset deassert, `state`=IF.
- `instr_done` and `illegal` are high for exactly one cycle per instruction.
- The controller never asserts `mem_write` and `reg_write` in the same cycle.

## Test plan
- Reset in MRD with `mem_ready`=0 → next cycle `state`=0 and all outputs 0. After release, IF with `mem_read`=1.
- lw (opcode 100011), `mem_ready`=1 → state sequence 0,1,2,3,4,0. `reg_write`=1 and `mem_to_reg`=1 only in state 4. `instr_done` pulses once.
- sw with `mem_ready` low for 3 cycles in MWR → `mem_write` high for 4 cycles. `instr_done` is asserted on the 4th. Total 7 cycles.
- R-type, funct 101010 → `alu_ctrl`=111 in REX, then RWB with `reg_dst`=1. Funct 000111 → `illegal` pulses in REX, RWB skipped, `reg_write` never asserted.
- beq with `zero`=1 → `pc_en`=1 and `pc_source`=01 in BR. bne with `zero`=1 → `pc_en`=0. Both take 3 cycles.
- Opcode 111111 → `illegal` and `instr_done` in ID, back to IF after 2 cycles. j (000010) → `pc_en`=1 and `pc_source`=10 in state 11.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a shared datapath.
// Moore outputs decoded from state_q (gated by mem_ready/zero); IF, MRD, MWR hold until mem_ready.
module mc_ctrl_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [2:0] alu_ctrl,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_MADDR = 4'd2,
        S_MRD   = 4'd3,
        S_MWB   = 4'd4,
        S_MWR   = 4'd5,
        S_REX   = 4'd6,
        S_RWB   = 4'd7,
        S_IEX   = 4'd8,
        S_IWB   = 4'd9,
        S_BR    = 4'd10,
        S_JMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] rex_alu;
    logic       rex_ok;
    logic [2:0] iex_alu;
    logic       iex_ext;

    always_comb begin
        rex_alu = ALU_ADD;
        rex_ok  = 1'b1;
        case (funct)
            FN_ADD:  rex_alu = ALU_ADD;
            FN_SUB:  rex_alu = ALU_SUB;
            FN_AND:  rex_alu = ALU_AND;
            FN_OR:   rex_alu = ALU_OR;
            FN_SLT:  rex_alu = ALU_SLT;
            default: rex_ok  = 1'b0;
        endcase
    end

    always_comb begin
        iex_alu = ALU_ADD;
        iex_ext = 1'b0;
        case (opcode)
            OP_ANDI: begin iex_alu = ALU_AND; iex_ext = 1'b1; end
            OP_ORI:  begin iex_alu = ALU_OR;  iex_ext = 1'b1; end
            default: iex_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:    state_d = mem_ready ? S_ID : S_IF;
            S_ID: begin
                case (opcode)
                    OP_LW, OP_SW:              state_d = S_MADDR;
                    OP_RTYPE:                  state_d = S_REX;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IEX;
                    OP_BEQ, OP_BNE:            state_d = S_BR;
                    OP_J:                      state_d = S_JMP;
                    default:                   state_d = S_IF;
                endcase
            end
            S_MADDR: state_d = (opcode == OP_LW) ? S_MRD : S_MWR;
            S_MRD:   state_d = mem_ready ? S_MWB : S_MRD;
            S_MWB:   state_d = S_IF;
            S_MWR:   state_d = mem_ready ? S_IF : S_MWR;
            S_REX:   state_d = rex_ok ? S_RWB : S_IF;
            S_RWB:   state_d = S_IF;
            S_IEX:   state_d = S_IWB;
            S_IWB:   state_d = S_IF;
            S_BR:    state_d = S_IF;
            S_JMP:   state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset blanks every output in the same cycle so an abandoned instruction writes nothing.
    always_comb begin
        pc_en      = 1'b0;
        pc_source  = PCSRC_ALU;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        ext_zero   = 1'b0;
        alu_ctrl   = ALU_AND;
        state      = 4'd0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            state = state_q;
            case (state_q)
                S_IF: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_ctrl  = ALU_ADD;
                    pc_source = PCSRC_ALU;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                end
                S_ID: begin
                    alu_src_b = SRCB_BOFF;
                    alu_ctrl  = ALU_ADD;
                    case (opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI,
                        OP_BEQ, OP_BNE, OP_J: illegal = 1'b0;
                        default: begin
                            illegal    = 1'b1;
                            instr_done = 1'b1;
                        end
                    endcase
                end
                S_MADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_ctrl  = ALU_ADD;
                end
                S_MRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MWR: begin
                    mem_write  = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                end
                S_REX: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_B;
                    alu_ctrl   = rex_alu;
                    illegal    = ~rex_ok;
                    instr_done = ~rex_ok;
                end
                S_RWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                S_IEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_ctrl  = iex_alu;
                    ext_zero  = iex_ext;
                end
                S_IWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_B;
                    alu_ctrl   = ALU_SUB;
                    pc_source  = PCSRC_ALUOUT;
                    pc_en      = (opcode == OP_BNE) ? ~zero : zero;
                    instr_done = 1'b1;
                end
                S_JMP: begin
                    pc_source  = PCSRC_JUMP;
                    pc_en      = 1'b1;
                    instr_done = 1'b1;
                end
                default: state = state_q;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: inputs change 1ns after posedge, outputs sampled on negedge.
module tb_mc_ctrl_fsm;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [2:0] alu_ctrl;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal;

    int vec;
    int err;

    mc_ctrl_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .pc_source  (pc_source),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_zero   (ext_zero),
        .alu_ctrl   (alu_ctrl),
        .state      (state),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [27:0] all_out;
    assign all_out = {pc_en, pc_source, iord, mem_read, mem_write, ir_write, reg_dst,
                      mem_to_reg, reg_write, alu_src_a, alu_src_b, ext_zero, alu_ctrl,
                      state, instr_done, illegal, 6'd0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        vec++; if (all_out !== 28'd0) begin err++; $display("FAIL rst_outputs got %h exp 0", all_out); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        vec++; if (state !== 4'd0) begin err++; $display("FAIL rst_release_state got %0d exp 0", state); end
        vec++; if (mem_read !== 1'b1) begin err++; $display("FAIL rst_release_mem_read got %b exp 1", mem_read); end
        vec++; if (ir_write !== 1'b0) begin err++; $display("FAIL if_stall_ir_write got %b exp 0", ir_write); end
        tick();
        // drive a lw into MRD, then reset while memory is still busy
        opcode = 6'b100011; mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        @(negedge clk);
        vec++; if (state !== 4'd3 || iord !== 1'b1) begin err++; $display("FAIL mrd_reach got st=%0d iord=%b exp st=3 iord=1", state, iord); end
        tick();
        rst = 1'b1;
        @(negedge clk);
        vec++; if (all_out !== 28'd0) begin err++; $display("FAIL rst_mid_outputs got %h exp 0", all_out); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        vec++; if (state !== 4'd0 || mem_read !== 1'b1) begin err++; $display("FAIL rst_mid_release got st=%0d rd=%b exp st=0 rd=1", state, mem_read); end
        tick();
        // leave IF waiting for the next test: still mem_ready=0 so state stays IF
        vec++; if (state !== 4'd0) begin err++; $display("FAIL if_hold got %0d exp 0", state); end
    endtask

    task automatic test_lw();
        int exp_st[5] = '{0, 1, 2, 3, 4};
        int done_cnt = 0;
        opcode = 6'b100011; funct = 6'd0; mem_ready = 1'b1; zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vec++; if (state !== 4'(exp_st[i])) begin err++; $display("FAIL lw_state[%0d] got %0d exp %0d", i, state, exp_st[i]); end
            vec++; if (reg_write !== (exp_st[i] == 4) || mem_to_reg !== (exp_st[i] == 4)) begin
                err++; $display("FAIL lw_wb[%0d] got rw=%b m2r=%b exp %b", i, reg_write, mem_to_reg, exp_st[i] == 4);
            end
            if (exp_st[i] == 0) begin
                vec++; if (ir_write !== 1'b1 || pc_en !== 1'b1 || alu_src_b !== 2'b01) begin
                    err++; $display("FAIL lw_fetch got ir=%b pc=%b srcb=%b exp 1 1 01", ir_write, pc_en, alu_src_b);
                end
            end
            if (exp_st[i] == 2) begin
                vec++; if (alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || alu_ctrl !== 3'b010) begin
                    err++; $display("FAIL lw_maddr got a=%b b=%b alu=%b exp 1 10 010", alu_src_a, alu_src_b, alu_ctrl);
                end
            end
            if (instr_done === 1'b1) done_cnt++;
            tick();
        end
        vec++; if (state !== 4'd0) begin err++; $display("FAIL lw_end_state got %0d exp 0", state); end
        vec++; if (done_cnt != 1) begin err++; $display("FAIL lw_done_count got %0d exp 1", done_cnt); end
    endtask

    task automatic test_sw_stall();
        int  exp_st[7] = '{0, 1, 2, 5, 5, 5, 5};
        logic rdy[7]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int wr_cnt = 0;
        int done_at = -1;
        int done_cnt = 0;
        opcode = 6'b101011;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            vec++; if (state !== 4'(exp_st[i])) begin err++; $display("FAIL sw_state[%0d] got %0d exp %0d", i, state, exp_st[i]); end
            vec++; if (mem_write === 1'b1 && reg_write === 1'b1) begin err++; $display("FAIL sw_wr_conflict[%0d] got both 1 exp not both", i); end
            if (mem_write === 1'b1) wr_cnt++;
            if (instr_done === 1'b1) begin done_cnt++; done_at = i; end
            tick();
        end
        mem_ready = 1'b1;
        vec++; if (wr_cnt != 4) begin err++; $display("FAIL sw_write_cycles got %0d exp 4", wr_cnt); end
        vec++; if (done_cnt != 1 || done_at != 6) begin err++; $display("FAIL sw_done got cnt=%0d at=%0d exp cnt=1 at=6", done_cnt, done_at); end
        vec++; if (state !== 4'd0) begin err++; $display("FAIL sw_end_state got %0d exp 0", state); end
    endtask

    task automatic test_rtype();
        int exp_st[4] = '{0, 1, 6, 7};
        int rw_cnt = 0;
        opcode = 6'b000000; funct = 6'b101010; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec++; if (state !== 4'(exp_st[i])) begin err++; $display("FAIL rt_state[%0d] got %0d exp %0d", i, state, exp_st[i]); end
            if (i == 2) begin
                vec++; if (alu_ctrl !== 3'b111 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin
                    err++; $display("FAIL rt_slt got alu=%b a=%b b=%b exp 111 1 00", alu_ctrl, alu_src_a, alu_src_b);
                end
            end
            if (i == 3) begin
                vec++; if (reg_dst !== 1'b1 || reg_write !== 1'b1 || instr_done !== 1'b1) begin
                    err++; $display("FAIL rt_rwb got dst=%b rw=%b done=%b exp 1 1 1", reg_dst, reg_write, instr_done);
                end
            end
            tick();
        end
        vec++; if (state !== 4'd0) begin err++; $display("FAIL rt_end_state got %0d exp 0", state); end
        // SUB funct: only the ALU control in REX is checked
        funct = 6'b100010;
        tick(); tick();
        @(negedge clk);
        vec++; if (alu_ctrl !== 3'b110) begin err++; $display("FAIL rt_sub got %b exp 110", alu_ctrl); end
        tick(); tick();
        // Undecodable funct: illegal in REX, RWB skipped
        funct = 6'b000111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec++; if (state !== 4'(exp_st[i])) begin err++; $display("FAIL rtbad_state[%0d] got %0d exp %0d", i, state, exp_st[i]); end
            vec++; if (illegal !== (i == 2) || instr_done !== (i == 2)) begin
                err++; $display("FAIL rtbad_pulse[%0d] got ill=%b done=%b exp %b", i, illegal, instr_done, i == 2);
            end
            if (reg_write === 1'b1) rw_cnt++;
            tick();
        end
        vec++; if (state !== 4'd0 || rw_cnt != 0) begin err++; $display("FAIL rtbad_end got st=%0d rw=%0d exp 0 0", state, rw_cnt); end
    endtask

    task automatic test_iex();
        int exp_st[4] = '{0, 1, 8, 9};
        opcode = 6'b001101; funct = 6'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec++; if (state !== 4'(exp_st[i])) begin err++; $display("FAIL ori_state[%0d] got %0d exp %0d", i, state, exp_st[i]); end
            if (i == 2) begin
                vec++; if (alu_ctrl !== 3'b001 || ext_zero !== 1'b1 || alu_src_b !== 2'b10) begin
                    err++; $display("FAIL ori_iex got alu=%b ez=%b b=%b exp 001 1 10", alu_ctrl, ext_zero, alu_src_b);
                end
            end
            if (i == 3) begin
                vec++; if (reg_write !== 1'b1 || reg_dst !== 1'b0 || instr_done !== 1'b1) begin
                    err++; $display("FAIL ori_iwb got rw=%b dst=%b done=%b exp 1 0 1", reg_write, reg_dst, instr_done);
                end
            end
            tick();
        end
        vec++; if (state !== 4'd0) begin err++; $display("FAIL ori_end_state got %0d exp 0", state); end
    endtask

    task automatic test_branch();
        zero = 1'b1;
        for (int k = 0; k < 2; k++) begin
            opcode = (k == 0) ? 6'b000100 : 6'b000101;
            tick(); tick();
            @(negedge clk);
            vec++; if (state !== 4'd10) begin err++; $display("FAIL br%0d_state got %0d exp 10", k, state); end
            vec++; if (pc_en !== (k == 0) || pc_source !== 2'b01) begin
                err++; $display("FAIL br%0d_pc got en=%b src=%b exp %b 01", k, pc_en, pc_source, k == 0);
            end
            vec++; if (alu_ctrl !== 3'b110 || instr_done !== 1'b1) begin
                err++; $display("FAIL br%0d_sub got alu=%b done=%b exp 110 1", k, alu_ctrl, instr_done);
            end
            tick();
            vec++; if (state !== 4'd0) begin err++; $display("FAIL br%0d_end_state got %0d exp 0", k, state); end
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal_op();
        opcode = 6'b111111;
        @(negedge clk);
        vec++; if (illegal !== 1'b0) begin err++; $display("FAIL illop_if got %b exp 0", illegal); end
        tick();
        @(negedge clk);
        vec++; if (state !== 4'd1 || illegal !== 1'b1 || instr_done !== 1'b1) begin
            err++; $display("FAIL illop_id got st=%0d ill=%b done=%b exp 1 1 1", state, illegal, instr_done);
        end
        tick();
        vec++; if (state !== 4'd0) begin err++; $display("FAIL illop_end_state got %0d exp 0", state); end
    endtask

    task automatic test_back_to_back();
        // Fetch stall of two cycles followed by a jump
        opcode = 6'b000010;
        mem_ready = 1'b0;
        tick(); tick();
        vec++; if (state !== 4'd0) begin err++; $display("FAIL stall_state got %0d exp 0", state); end
        mem_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        vec++; if (state !== 4'd11 || pc_en !== 1'b1 || pc_source !== 2'b10) begin
            err++; $display("FAIL jmp got st=%0d en=%b src=%b exp 11 1 10", state, pc_en, pc_source);
        end
        tick();
        vec++; if (state !== 4'd0) begin err++; $display("FAIL jmp_end_state got %0d exp 0", state); end
    endtask

    initial begin
        vec = 0;
        err = 0;
        test_reset();
        test_lw();
        test_sw_stall();
        test_rtype();
        test_iex();
        test_branch();
        test_illegal_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
